// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/mem/writeback for M_datapath.
// Optional macro MC_CTRL_JAL_JR_EN adds the JAL and JR states; without it jal/jr decode as illegal.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic        MIO_ready,
  input  logic        zero,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        Branch,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  RegDst,
  output logic [2:0]  ALU_operation,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MRD = 4'd3,
    S_LWB = 4'd4,
    S_MWR = 4'd5,
    S_REX = 4'd6,
    S_RWB = 4'd7,
    S_BEX = 4'd8,
    S_J   = 4'd9,
    S_IEX = 4'd10,
    S_IWB = 4'd11,
`ifdef MC_CTRL_JAL_JR_EN
    S_JAL = 4'd12,
    S_JR  = 4'd13,
`endif
    S_LUI = 4'd14,
    S_ILL = 4'd15
  } st_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] F_JR    = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  st_t        st, st_nxt;
  logic [5:0] opcode, funct;
  logic [2:0] r_alu, i_alu;
  logic       r_ok;
  logic       unused_bits;

  assign opcode      = Inst[31:26];
  assign funct       = Inst[5:0];
  assign unused_bits = ^{Inst[25:6], zero};

  always_comb begin
    r_alu = ALU_ADD;
    r_ok  = 1'b1;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100110: r_alu = ALU_XOR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      6'b000010: r_alu = ALU_SRL;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    i_alu = ALU_ADD;
    case (opcode)
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_SLTI: i_alu = ALU_SLT;
      default: i_alu = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_IF;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = S_IF;
    case (st)
      S_IF:  st_nxt = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW: st_nxt = S_MA;
          OP_R: begin
`ifdef MC_CTRL_JAL_JR_EN
            if (funct == F_JR) st_nxt = S_JR;
            else
`endif
            st_nxt = r_ok ? S_REX : S_ILL;
          end
          OP_BEQ, OP_BNE:                    st_nxt = S_BEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: st_nxt = S_IEX;
          OP_LUI:                            st_nxt = S_LUI;
          OP_J:                              st_nxt = S_J;
`ifdef MC_CTRL_JAL_JR_EN
          OP_JAL:                            st_nxt = S_JAL;
`endif
          default:                           st_nxt = S_ILL;
        endcase
      end
      S_MA:  st_nxt = (opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD: st_nxt = MIO_ready ? S_LWB : S_MRD;
      S_MWR: st_nxt = MIO_ready ? S_IF : S_MWR;
      S_REX: st_nxt = S_RWB;
      S_IEX: st_nxt = S_IWB;
      default: st_nxt = S_IF;
    endcase
  end

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
    RegWrite = 1'b0; ALUSrcA = 1'b0; Branch = 1'b0; MemtoReg = 2'b00;
    PCSource = 2'b00; ALUSrcB = 2'b00; RegDst = 2'b00; ALU_operation = ALU_AND;
    MemRead = 1'b0; MemWrite = 1'b0;
    case (st)
      S_IF: begin
        MemRead = 1'b1; ALUSrcB = 2'b01; ALU_operation = ALU_ADD;
        IRWrite = MIO_ready; PCWrite = MIO_ready;
      end
      S_ID:  begin ALUSrcB = 2'b11; ALU_operation = ALU_ADD; end
      S_MA:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = ALU_ADD; end
      S_MRD: begin MemRead = 1'b1; IorD = 1'b1; end
      S_LWB: begin RegWrite = 1'b1; MemtoReg = 2'b01; end
      S_MWR: begin MemWrite = 1'b1; IorD = 1'b1; end
      S_REX: begin ALUSrcA = 1'b1; ALU_operation = r_alu; end
      S_RWB: begin RegWrite = 1'b1; RegDst = 2'b01; ALU_operation = r_alu; end
      S_BEX: begin
        ALUSrcA = 1'b1; ALU_operation = ALU_SUB; PCWriteCond = 1'b1;
        PCSource = 2'b01; Branch = (opcode == OP_BEQ);
      end
      S_J:   begin PCWrite = 1'b1; PCSource = 2'b10; end
      S_IEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = i_alu; end
      S_IWB: RegWrite = 1'b1;
`ifdef MC_CTRL_JAL_JR_EN
      S_JAL: begin
        RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b11;
        PCWrite = 1'b1; PCSource = 2'b10;
      end
      S_JR:  begin PCWrite = 1'b1; PCSource = 2'b11; end
`endif
      S_LUI: begin RegWrite = 1'b1; MemtoReg = 2'b10; end
      default: ;
    endcase
    // state is already IF during reset, but IF strobes follow MIO_ready and must be masked
    if (reset) begin
      PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0;
      MemWrite = 1'b0; PCWriteCond = 1'b0;
    end
  end

  assign CPU_MIO = MemRead | MemWrite;
  assign state   = st;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle MIPS control unit that drives `M_datapath`. It decodes the instruction register word and sequences fetch, decode, execute, memory and writeback states. For each state it emits every datapath control field plus the memory request strobes. It waits on `MIO_ready` for every memory access.

## Interface
- No parameters (state encoding fixed below).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; forces state IF.
- `Inst`  in  32  instruction register output of `M_datapath`.
- `MIO_ready`  in  1  memory/IO handshake; access completes on a rising edge with `MIO_ready`=1.
- `zero`  in  1  ALU zero flag from `M_datapath`.
- `PCWrite`, `PCWriteCond`, `IorD`, `IRWrite`, `RegWrite`, `ALUSrcA`, `Branch`  out  1 each  datapath controls.
- `MemtoReg`, `PCSource`, `ALUSrcB`, `RegDst`  out  2 each  datapath mux selects.
- `ALU_operation`  out  3  ALU function select.
- `MemRead`, `MemWrite`, `CPU_MIO`  out  1 each  memory strobes; `CPU_MIO` = `MemRead | MemWrite`.
- `state`  out  4  current state, for debug.

## Operation
- Encodings:
  - ALU_operation: 000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
  - ALUSrcA: 0=PC, 1=A. ALUSrcB: 00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2.
  - PCSource: 00=ALU result, 01=ALUOut, 10=jump target, 11=A.
  - MemtoReg: 00=ALUOut, 01=MDR, 10=imm<<16, 11=PC.
  - RegDst: 00=rt, 01=rd, 10=$31.
  - Datapath PC enable = `PCWrite | (PCWriteCond & (Branch ? zero : ~zero))`.
- Moore outputs come from the state register; every output not listed for a state is 0. States and their outputs:
  - IF(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSource=00. `IRWrite` and `PCWrite` = `MIO_ready`. Stays in IF while `MIO_ready`=0; otherwise goes to ID.
  - ID(1): ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state from opcode:
    - lw/sw → MA; R-type → REX, except funct 001000 → JR.
    - beq/bne → BEX; addi/andi/ori/slti → IEX; lui → LUI; j → J; jal → JAL.
    - anything else → ILL.
  - MA(2): ALUSrcA=1, ALUSrcB=10, add. Next: MRD for lw, MWR for sw.
  - MRD(3): MemRead, IorD=1. Holds until `MIO_ready`, then goes to LWB.
  - LWB(4): RegWrite, RegDst=00, MemtoReg=01. Next IF.
  - MWR(5): MemWrite, IorD=1. Holds until `MIO_ready`, then goes to IF.
  - REX(6): ALUSrcA=1, ALUSrcB=00. ALU op from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl. Any other funct → ILL instead of REX (decided in ID). Next RWB.
  - RWB(7): RegWrite, RegDst=01, MemtoReg=00; ALU_operation held at the REX value. Next IF.
  - BEX(8): ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond, PCSource=01. Branch=1 for beq, 0 for bne. Next IF.
  - J(9): PCWrite, PCSource=10. Next IF.
  - IEX(10): ALUSrcA=1, ALUSrcB=10. ALU op: addi add, andi and, ori or, slti slt. andi/ori use the sign-extended immediate because the datapath has only one extender. Next IWB.
  - IWB(11): RegWrite, RegDst=00, MemtoReg=00. Next IF.
  - JAL(12): RegWrite, RegDst=10, MemtoReg=11 (PC already holds PC+4), PCWrite, PCSource=10. Next IF.
  - JR(13): PCWrite, PCSource=11. Next IF.
  - LUI(14): RegWrite, RegDst=00, MemtoReg=10. Next IF.
  - ILL(15): no writes. Next IF, so the instruction is skipped and PC already holds PC+4.

## Timing
- Cycles per instruction with no stalls: lw 5; R-type, addi-class and sw 4; beq/bne, j, jal, jr, lui and illegal 3.
- Each cycle `MIO_ready`=0 in IF, MRD or MWR adds one cycle. Outputs are held stable during the stall.
- `Inst` must be stable from ID until the return to IF. IR loads only at the IF exit edge.
- While `reset`=1: state=IF, `state`=0, and `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `PCWriteCond` are forced 0. Remaining outputs take their IF values.
- Reset asserted mid-instruction aborts the instruction immediately. No partial write follows deassertion.
- First fetch occurs on the first rising edge after deassertion with `MIO_ready`=1.

## Configuration
- `MC_CTRL_JAL_JR_EN` defined: jal (opcode 000011) and jr (R-type funct 001000) decode to JAL and JR.
- Not defined: both decode to ILL and the JAL/JR states are absent; `state` never reads 12 or 13.

## Test plan
- `add r3,r2,r2` (0x00421820), `MIO_ready`=1 → state sequence 0,1,6,7,0.
  - REX: ALU_operation=010.
  - RWB: RegWrite=1, RegDst=01.
  - IRWrite=PCWrite=1 only in IF.
- `lw r1,4(r0)` (0x8C010004) with `MIO_ready`=0 for 2 cycles in MRD → MRD lasts 3 cycles with MemRead=1, IorD=1; then LWB with MemtoReg=01, RegWrite=1.
- `sw r1,8(r0)` (0xAC010008) → states 0,1,2,5,0; MemWrite=1 and CPU_MIO=1 in MWR only; RegWrite never asserted.
- `beq r0,r0,4` (0x10000004), then `bne` (0x14000004) → BEX with PCWriteCond=1, PCSource=01, ALU_operation=110; Branch=1 for beq, 0 for bne.
- Opcode 111111, then `jr $31` (0x03E00008) with the macro undefined → both take path 0,1,15,0 with no write strobes. With the macro defined, jr takes 0,1,13,0 with PCSource=11.
- Assert `reset` during MWR → `MemWrite` drops to 0 asynchronously and state=0. After release, IF resumes.
